tcm_arbiter: RTL and testbench



---
 rtl/tcm_arbiter.sv | 157 +++++++++++++++
 tb/tb_tcm_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_arbiter.sv
// tcm_arbiter: shares one TCM SRAM port between the core data side (M0) and
// the DMA/loader (M1). One access per cycle is issued to the SRAM in the
// accept cycle; the response (ready/data/err) returns to the owner one cycle
// later. Out-of-window addresses are granted but never reach the SRAM, and
// they return an error response.
//
// Optional feature: define TCM_ARB_STARVE_EN to enable the M1 starvation
// guard. M1 wins over M0 once it has waited STARVE_LIMIT consecutive cycles.
// Without the macro, M0 has strict priority.
module tcm_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned N_ENTRIES    = 1024,
  parameter logic [31:0] TCM_BASE     = 32'h0000_0000,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m0_req_i,
  input  logic                         m0_we_i,
  input  logic [DATA_WIDTH/8-1:0]      m0_be_i,
  input  logic [31:0]                  m0_addr_i,
  input  logic [DATA_WIDTH-1:0]        m0_data_i,
  output logic                         m0_gnt_o,
  output logic                         m0_ready_o,
  output logic [DATA_WIDTH-1:0]        m0_data_o,
  output logic                         m0_err_o,
  input  logic                         m1_req_i,
  input  logic                         m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]      m1_be_i,
  input  logic [31:0]                  m1_addr_i,
  input  logic [DATA_WIDTH-1:0]        m1_data_i,
  output logic                         m1_gnt_o,
  output logic                         m1_ready_o,
  output logic [DATA_WIDTH-1:0]        m1_data_o,
  output logic                         m1_err_o,
  output logic                         sram_en_o,
  output logic                         sram_we_o,
  output logic [DATA_WIDTH/8-1:0]      sram_be_o,
  output logic [$clog2(N_ENTRIES)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]        sram_data_o,
  input  logic [DATA_WIDTH-1:0]        sram_data_i
);

  localparam int unsigned BE_W      = DATA_WIDTH / 8;
  localparam int unsigned AW        = $clog2(N_ENTRIES);
  localparam int unsigned OFF_W     = $clog2(BE_W);
  localparam logic [32:0] WIN_BYTES = 33'(N_ENTRIES) * 33'(BE_W);

  // M1 overrides M0 when the starvation guard fires this cycle
  logic starve_win;

`ifdef TCM_ARB_STARVE_EN
  logic [7:0] starve_cnt_q;

  assign starve_win = m1_req_i && (starve_cnt_q == 8'(STARVE_LIMIT));

  // Count consecutive cycles M1 waits without a grant; saturate at 255
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else if (m1_req_i && !m1_gnt_o) begin
      if (starve_cnt_q != 8'hFF) begin
        starve_cnt_q <= starve_cnt_q + 8'd1;
      end
    end else begin
      starve_cnt_q <= '0;
    end
  end
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
  assign starve_win = 1'b0;
`endif

  // Grants are purely combinational; nothing is granted while in reset
  assign m1_gnt_o = !rst_i && m1_req_i && (!m0_req_i || starve_win);
  assign m0_gnt_o = !rst_i && m0_req_i && !starve_win;

  logic                  accept;
  logic                  sel_m1;
  logic                  sel_we;
  logic [BE_W-1:0]       sel_be;
  logic [31:0]           sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [32:0]           win_off;
  logic [32:0]           win_word;
  logic                  in_win;
  logic                  unused_word_hi;

  assign accept = m0_gnt_o || m1_gnt_o;
  assign sel_m1 = m1_gnt_o;

  // Route the winning requester's attributes toward the SRAM port
  always_comb begin
    sel_we   = m0_we_i;
    sel_be   = m0_be_i;
    sel_addr = m0_addr_i;
    sel_data = m0_data_i;
    if (sel_m1) begin
      sel_we   = m1_we_i;
      sel_be   = m1_be_i;
      sel_addr = m1_addr_i;
      sel_data = m1_data_i;
    end
  end

  // The extra top bit goes high for addresses below the base, which then
  // compare as huge and fall outside the window
  assign win_off        = {1'b0, sel_addr} - {1'b0, TCM_BASE};
  assign in_win         = (win_off < WIN_BYTES);
  assign win_word       = win_off >> OFF_W;
  assign unused_word_hi = ^win_word[32:AW];

  // ---- stage boundary: request issued to SRAM this cycle ----
  assign sram_en_o   = accept && in_win;
  assign sram_we_o   = sram_en_o && sel_we;
  assign sram_be_o   = sram_en_o ? sel_be : '0;
  assign sram_addr_o = win_word[AW-1:0];
  assign sram_data_o = sel_data;

  logic resp_vld_q;
  logic resp_owner_q;
  logic resp_err_q;
  logic resp_we_q;

  // Capture who owns the response returning in the next cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_vld_q   <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      resp_vld_q <= accept;
      if (accept) begin
        resp_owner_q <= sel_m1;
        resp_err_q   <= !in_win;
        resp_we_q    <= sel_we;
      end
    end
  end

  // ---- stage boundary: response returned to owner ----
  logic                  resp_live;
  logic [DATA_WIDTH-1:0] resp_data;

  // A response pending when reset arrives is dropped, not shown
  assign resp_live  = resp_vld_q && !rst_i;
  assign resp_data  = (resp_err_q || resp_we_q) ? '0 : sram_data_i;

  assign m0_ready_o = resp_live && !resp_owner_q;
  assign m1_ready_o = resp_live && resp_owner_q;
  assign m0_err_o   = m0_ready_o && resp_err_q;
  assign m1_err_o   = m1_ready_o && resp_err_q;
  assign m0_data_o  = m0_ready_o ? resp_data : '0;
  assign m1_data_o  = m1_ready_o ? resp_data : '0;

endmodule

// File: tb/tb_tcm_arbiter.sv
// Bench for tcm_arbiter: table of single accesses, hand sequences for the
// multi-cycle corners, then randomized traffic against a behavioural model.
// Expectations adapt to whether TCM_ARB_STARVE_EN is defined.
`timescale 1ns/1ps
module tb_tcm_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned N     = 64;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned LIMIT = 8;
`ifdef TCM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m0_gnt, m0_ready, m0_err;
  logic [3:0] m0_be;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic m1_req, m1_we, m1_gnt, m1_ready, m1_err;
  logic [3:0] m1_be;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic sram_en, sram_we;
  logic [3:0] sram_be;
  logic [5:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic load_mem;

  always #5 clk = ~clk;

  tcm_arbiter #(.DATA_WIDTH(DW), .N_ENTRIES(N), .TCM_BASE(BASE), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_data_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_ready_o(m0_ready),
    .m0_data_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_data_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_ready_o(m1_ready),
    .m1_data_o(m1_rdata), .m1_err_o(m1_err),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_be_o(sram_be),
    .sram_addr_o(sram_addr), .sram_data_o(sram_wdata), .sram_data_i(sram_rdata)
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'h1122_3344 + (32'(k) << 24);
  endfunction

  // SRAM with registered read, byte-enabled writes
  logic [31:0] sram_mem [N];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < int'(N); i++) sram_mem[i] <= init_word(i);
    end else if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Expected memory contents as seen by the requesters
  logic [31:0] shadow [N];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic shadow_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
    int k;
    k = int'((addr - BASE) >> 2);
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[k][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return BASE + 32'(N * 4) + 32'($urandom_range(0, 255));
    if (r == 1) return BASE - 32'($urandom_range(1, 64));
    if (r < 6) return BASE + 32'($urandom_range(0, 31));
    return BASE + 32'($urandom_range(0, N * 4 - 1));
  endfunction

  typedef struct {
    logic        mst;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt0;
    logic        gnt1;
    logic        en;
    logic [5:0]  waddr;
    logic        rdy0;
    logic        rdy1;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  // Watchdog: the bench has no open-ended waits, this only guards the tools
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic e0, e1, pv, po, pe, h0, h1, inwin, swe;
    logic [31:0] pd, saddr, sdata, off;
    logic [3:0] sbe;
    int w;

    for (int i = 0; i < int'(N); i++) shadow[i] = init_word(i);

    //            mst we  be       addr                         wdata          g0 g1 en wa  r0 r1 er rdata
    vecs[0]  = '{1'b0, 1'b1, 4'hF, BASE + 32'h8,                 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 6'd2,  1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 4'hF, BASE + 32'h8,                 32'h0,        1'b1, 1'b0, 1'b1, 6'd2,  1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 4'hF, BASE,                         32'h0,        1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 32'h11223344};
    vecs[3]  = '{1'b1, 1'b1, 4'h2, BASE,                         32'h0000AB00, 1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 4'hF, BASE + 32'h1,                 32'h0,        1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 32'h1122AB44};
    vecs[5]  = '{1'b0, 1'b0, 4'hF, BASE + 32'h100,               32'h0,        1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 4'hF, BASE - 32'h4,                 32'h0,        1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 4'h8, BASE + 32'h8,                 32'hAA000000, 1'b1, 1'b0, 1'b1, 6'd2,  1'b1, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 4'hF, BASE + 32'h8,                 32'h0,        1'b1, 1'b0, 1'b1, 6'd2,  1'b1, 1'b0, 1'b0, 32'hAAADBEEF};
    vecs[9]  = '{1'b1, 1'b0, 4'hF, BASE + 32'hFF,                32'h0,        1'b0, 1'b1, 1'b1, 6'd63, 1'b0, 1'b1, 1'b0, 32'h50223344};
    vecs[10] = '{1'b1, 1'b1, 4'hF, BASE + 32'h110,               32'h12345678, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 32'h0};

    // Reset: requests present during reset are never granted
    set_idle();
    rst = 1; load_mem = 1;
    m0_req = 1; m1_req = 1;
    tick();
    load_mem = 0;
    @(negedge clk);
    chk1("rst m0_gnt", m0_gnt, 1'b0);
    chk1("rst m1_gnt", m1_gnt, 1'b0);
    chk1("rst sram_en", sram_en, 1'b0);
    chk1("rst m0_ready", m0_ready, 1'b0);
    chk1("rst m1_ready", m1_ready, 1'b0);
    chk("rst m0_data", m0_rdata, 32'h0);
    chk1("rst m0_err", m0_err, 1'b0);
    tick();
    rst = 0; set_idle();
    @(negedge clk);
    chk1("post-rst m0_ready", m0_ready, 1'b0);
    chk1("post-rst m1_ready", m1_ready, 1'b0);
    chk1("post-rst sram_en", sram_en, 1'b0);
    tick();

    // Table of single accesses, each followed by an idle response cycle
    for (int i = 0; i < NV; i++) begin
      set_idle();
      if (vecs[i].mst) begin
        m1_req = 1; m1_we = vecs[i].we; m1_be = vecs[i].be; m1_addr = vecs[i].addr; m1_wdata = vecs[i].wdata;
      end else begin
        m0_req = 1; m0_we = vecs[i].we; m0_be = vecs[i].be; m0_addr = vecs[i].addr; m0_wdata = vecs[i].wdata;
      end
      @(negedge clk);
      chk1($sformatf("vec%0d m0_gnt", i), m0_gnt, vecs[i].gnt0);
      chk1($sformatf("vec%0d m1_gnt", i), m1_gnt, vecs[i].gnt1);
      chk1($sformatf("vec%0d sram_en", i), sram_en, vecs[i].en);
      if (vecs[i].en) begin
        chk1($sformatf("vec%0d sram_we", i), sram_we, vecs[i].we);
        chk($sformatf("vec%0d sram_addr", i), 32'(sram_addr), 32'(vecs[i].waddr));
        if (vecs[i].we) chk($sformatf("vec%0d sram_be", i), 32'(sram_be), 32'(vecs[i].be));
        if (vecs[i].we) shadow_write(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      end
      tick();
      set_idle();
      @(negedge clk);
      chk1($sformatf("vec%0d m0_ready", i), m0_ready, vecs[i].rdy0);
      chk1($sformatf("vec%0d m1_ready", i), m1_ready, vecs[i].rdy1);
      chk1($sformatf("vec%0d m0_err", i), m0_err, vecs[i].rdy0 & vecs[i].err);
      chk1($sformatf("vec%0d m1_err", i), m1_err, vecs[i].rdy1 & vecs[i].err);
      chk($sformatf("vec%0d m0_data", i), m0_rdata, vecs[i].rdy0 ? vecs[i].rdata : 32'h0);
      chk($sformatf("vec%0d m1_data", i), m1_rdata, vecs[i].rdy1 ? vecs[i].rdata : 32'h0);
      tick();
    end

    // Back-to-back M0 write then read of the same word
    set_idle();
    m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = BASE + 32'hC; m0_wdata = 32'h0BADF00D;
    @(negedge clk);
    chk1("b2b wr gnt", m0_gnt, 1'b1);
    chk1("b2b wr sram_we", sram_we, 1'b1);
    chk("b2b wr sram_addr", 32'(sram_addr), 32'd3);
    tick();
    shadow_write(BASE + 32'hC, 4'hF, 32'h0BADF00D);
    m0_we = 0; m0_wdata = 0;
    @(negedge clk);
    chk1("b2b rd gnt", m0_gnt, 1'b1);
    chk1("b2b wr ready", m0_ready, 1'b1);
    chk("b2b wr data", m0_rdata, 32'h0);
    tick();
    set_idle();
    @(negedge clk);
    chk1("b2b rd ready", m0_ready, 1'b1);
    chk("b2b rd data", m0_rdata, 32'h0BADF00D);
    tick();
    @(negedge clk);
    chk1("b2b ready one cycle", m0_ready, 1'b0);
    tick();

    // Continuous M0 and M1 reads: M1 starves unless the guard is built in
    set_idle();
    m0_req = 1; m0_addr = BASE + 32'h8;
    m1_req = 1; m1_addr = BASE;
    for (int c = 1; c <= 20; c++) begin
      logic exp1;
      exp1 = STARVE_EN && (c == int'(LIMIT) + 1);
      @(negedge clk);
      chk1($sformatf("starve c%0d m1_gnt", c), m1_gnt, exp1);
      chk1($sformatf("starve c%0d m0_gnt", c), m0_gnt, !exp1);
      tick();
      if (exp1) m1_req = 0;
    end
    set_idle();
    tick();

    // Reset in the cycle a response is due: the response is dropped
    set_idle();
    m0_req = 1; m0_addr = BASE + 32'h8;
    @(negedge clk);
    chk1("rstpend accept gnt", m0_gnt, 1'b1);
    tick();
    rst = 1;
    @(negedge clk);
    chk1("rstpend m0_ready", m0_ready, 1'b0);
    chk1("rstpend m1_ready", m1_ready, 1'b0);
    chk("rstpend m0_data", m0_rdata, 32'h0);
    chk1("rstpend m0_err", m0_err, 1'b0);
    chk1("rstpend m0_gnt", m0_gnt, 1'b0);
    chk1("rstpend sram_en", sram_en, 1'b0);
    tick();
    rst = 0;
    @(negedge clk);
    chk1("rstpend after ready", m0_ready, 1'b0);
    chk1("rstpend regrant", m0_gnt, 1'b1);
    chk1("rstpend regrant en", sram_en, 1'b1);
    tick();
    set_idle();
    @(negedge clk);
    chk1("rstpend fresh ready", m0_ready, 1'b1);
    chk("rstpend fresh data", m0_rdata, shadow[2]);
    tick();

    // Randomized traffic against the behavioural model
    h0 = 0; h1 = 0; w = 0; pv = 0; po = 0; pe = 0; pd = 0;
    for (int c = 0; c < 600; c++) begin
      if (!h0) begin
        m0_req = ($urandom_range(0, 9) < 8); m0_we = 1'($urandom_range(0, 1));
        m0_be = 4'($urandom); m0_addr = rand_addr(); m0_wdata = $urandom;
      end
      if (!h1) begin
        m1_req = ($urandom_range(0, 9) < 6); m1_we = 1'($urandom_range(0, 1));
        m1_be = 4'($urandom); m1_addr = rand_addr(); m1_wdata = $urandom;
      end
      @(negedge clk);
      e1 = m1_req && (!m0_req || (STARVE_EN && w == int'(LIMIT)));
      e0 = m0_req && !e1;
      chk1("rnd m0_gnt", m0_gnt, e0);
      chk1("rnd m1_gnt", m1_gnt, e1);
      chk1("rnd m0_ready", m0_ready, pv && !po);
      chk1("rnd m1_ready", m1_ready, pv && po);
      chk1("rnd m0_err", m0_err, pv && !po && pe);
      chk1("rnd m1_err", m1_err, pv && po && pe);
      chk("rnd m0_data", m0_rdata, (pv && !po) ? pd : 32'h0);
      chk("rnd m1_data", m1_rdata, (pv && po) ? pd : 32'h0);
      if (e0 || e1) begin
        saddr = e1 ? m1_addr : m0_addr;
        sdata = e1 ? m1_wdata : m0_wdata;
        sbe   = e1 ? m1_be : m0_be;
        swe   = e1 ? m1_we : m0_we;
        off   = saddr - BASE;
        inwin = (off < 32'(N * 4));
        chk1("rnd sram_en", sram_en, inwin);
        if (inwin) begin
          chk("rnd sram_addr", 32'(sram_addr), off >> 2);
          chk1("rnd sram_we", sram_we, swe);
          if (swe) begin
            chk("rnd sram_be", 32'(sram_be), 32'(sbe));
            chk("rnd sram_wdata", sram_wdata, sdata);
          end
        end
        pd = (inwin && !swe) ? shadow[int'(off >> 2)] : 32'h0;
        if (inwin && swe) shadow_write(saddr, sbe, sdata);
        pv = 1; po = e1; pe = !inwin;
      end else begin
        chk1("rnd idle sram_en", sram_en, 1'b0);
        pv = 0;
      end
      if (m1_req && !e1) w = (w < 255) ? w + 1 : w;
      else w = 0;
      h0 = m0_req && !e0;
      h1 = m1_req && !e1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
